sdr_aref_checker: RTL and testbench
===================================

// Module: sdr_aref_checker
// PURPOSE
//  Synthesizable, multi-chip-select auto-refresh timing checker on the SDRAM command bus.
//  Sits beside the SDRAM controller in the sdram_clk domain and decodes cs/ras/cas/we/cke.
//  Per chip select it measures the refresh-to-refresh gap and checks post-refresh recovery (tRCAR).
//  Checks the refresh deadline (rf_sh-derived) and reports gaps and errors as pulses plus sticky masks.
// PARAMETERS
//  CS_NUM    1   number of chip selects (independent channels), 1..8
//  CNT_W     16  width of per-channel cycle counters and reported gap
//  RF_SHIFT  0   refresh deadline = SDR_rf_sh << RF_SHIFT cycles
//  TOT_W     24  width of total-refresh counter
// PORTS
//  sdram_clk    in   1             command-bus clock
//  RESET        in   1             asynchronous, active-high reset
//  chk_en       in   1             0: all channels held in IDLE, no reports
//  sdr_cke      in   1             clock enable
//  sdr_cs_n     in   CS_NUM        chip selects, active low
//  sdr_ras_n    in   1             RAS
//  sdr_cas_n    in   1             CAS
//  sdr_we_n     in   1             WE
//  SDR_trcar_d  in   4             required recovery cycles after AREF
//  SDR_rf_sh    in   12            refresh period base
//  gap_valid    out  1             pulse: gap_cycles/gap_ch valid
//  gap_cycles   out  CNT_W         cycles between consecutive AREF starts (saturating)
//  gap_ch       out  $clog2(CS_NUM)+1  channel of reported gap
//  err_trcar    out  1             pulse: non-NOP command inside recovery window
//  err_late     out  1             pulse: refresh deadline exceeded
//  err_ch       out  $clog2(CS_NUM)+1  lowest-index channel of current error pulse
//  err_mask     out  CS_NUM        sticky per-channel error flags (cleared only by RESET)
//  aref_total   out  TOT_W         saturating count of AREF starts, all channels
// BEHAVIOUR
//  - Reset: all outputs 0; all channel FSMs IDLE; counters 0.
//  - Decode per channel c: AREF = cke & ~cs_n[c] & ~ras_n & ~cas_n & we_n. CMD = cke & ~cs_n[c] & ~(ras_n&cas_n&we_n).
//  - AREF start = AREF now & not AREF last cycle; consecutive AREF cycles merge into one start.
//  - FSM per channel: IDLE -> (AREF start) RECOVER; RECOVER -> ARMED when rcnt == SDR_trcar_d;
//    ARMED -> (AREF start) RECOVER; any state -> IDLE when chk_en=0 (synchronous, 1 cycle).
//  - RECOVER: rcnt counts from 1 on the cycle after the start; CMD with rcnt<=SDR_trcar_d -> err_trcar
//    (AREF continuation cycles excluded); FSM keeps counting, stays in RECOVER.
//  - SDR_trcar_d=0: RECOVER exits on the next cycle; no tRCAR check.
//  - gcnt: cleared to 1 on the cycle after each start, +1 per cycle, saturates at all-ones.
//  - AREF start from RECOVER/ARMED: gap_valid=1, gap_cycles=gcnt, aref_total+1 (saturating), registered 1 cycle.
//    Start from IDLE: aref_total+1 only, no gap report.
//  - err_late: one pulse when gcnt == (SDR_rf_sh<<RF_SHIFT)+1 in RECOVER/ARMED; no repeat until next start.
//  - Latency: all pulses appear 1 cycle after the sampled bus cycle.
//  - Simultaneous events on several channels in one cycle:
//    gap/err outputs report the lowest index; err_mask ORs all; aref_total adds the popcount.
//  - Gap reports from higher channels in the same cycle are dropped (only aref_total counts them).
//  - err_trcar and err_late in the same cycle: both pulse; err_ch = lowest erring channel of either.
//  - Config inputs are sampled live; changes mid-window apply immediately.
//  - RESET asserted mid-window: immediate clear; the first AREF after release is an IDLE start.
// STRUCTURE
//  - Package sdr_cmd_pkg: typedef enum {NOP,ACT,RD,WR,PRE,AREF,MRS,OTHER} sdr_cmd_e; decode function.
//    Also holds typedef enum {IDLE,RECOVER,ARMED} aref_st_e.
//  - Sub-module sdr_aref_chan: one channel's FSM and counters, instantiated CS_NUM times (generate).
//    Outputs start/gap/err_trcar/err_late to a top-level priority/merge and aref_total adder.
// TESTING
//  - RESET=1 mid-sequence, release, run 3 AREFs: outputs 0 during reset; first AREF gives only aref_total=1.
//  - CS_NUM=1, trcar_d=4, AREFs 100 cycles apart x3 -> gap_valid x2 with gap_cycles=100; aref_total=3; no errors.
//  - trcar_d=4, ACT 3 cycles after AREF -> err_trcar 1 cycle later, err_mask=1.
//    Same test with ACT 5 cycles after -> no error.
//  - rf_sh=50, RF_SHIFT=0, no AREF after first -> single err_late at gcnt=51.
//    Next AREF reports gap_cycles = elapsed cycles.
//  - AREF held 3 consecutive cycles -> one start; aref_total +1; no err_trcar.
//  - CS_NUM=4, AREF on cs 1 and 3 in one cycle, both later violate tRCAR together:
//    aref_total +2; err_ch=1; err_mask=4'b1010.
//    Also check chk_en=0 for 10 cycles clears FSMs: next AREF gives no gap report.

Source files
------------

// File: rtl/sdr_cmd_pkg.sv
// SDRAM command decode and auto-refresh checker shared types.
// Bus-level command enum, per-channel FSM states and event bundle.
package sdr_cmd_pkg;

    localparam int TRCAR_W = 4;
    localparam int RFSH_W  = 12;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        RD,
        WR,
        PRE,
        AREF,
        MRS,
        OTHER
    } sdr_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        ARMED
    } aref_st_e;

    typedef struct packed {
        logic start;
        logic gap;
        logic err_trcar;
        logic err_late;
    } chan_ev_t;

    // Deselected or clock-disabled cycles read as NOP.
    function automatic sdr_cmd_e sdr_decode(
        input logic cke,
        input logic cs_n,
        input logic ras_n,
        input logic cas_n,
        input logic we_n
    );
        sdr_cmd_e c;
        c = NOP;
        if (cke && !cs_n) begin
            unique case ({ras_n, cas_n, we_n})
                3'b111:  c = NOP;
                3'b011:  c = ACT;
                3'b101:  c = RD;
                3'b100:  c = WR;
                3'b010:  c = PRE;
                3'b001:  c = AREF;
                3'b000:  c = MRS;
                default: c = OTHER;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/sdr_aref_chan.sv
// One chip-select channel: refresh FSM, recovery and gap counters.
// Emits same-cycle events; the top registers and merges them.
module sdr_aref_chan
    import sdr_cmd_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int RF_SHIFT = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  sdr_cmd_e           cmd_i,
    input  logic [TRCAR_W-1:0] trcar_i,
    input  logic [RFSH_W-1:0]  rf_sh_i,
    output chan_ev_t           ev_o,
    output logic [CNT_W-1:0]   gcnt_o
);

    localparam int DL_W = RFSH_W + RF_SHIFT + 1;
    localparam int CW   = (CNT_W > DL_W) ? CNT_W : DL_W;

    aref_st_e           state_q, state_d;
    logic [TRCAR_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic               late_q, late_d;
    logic               aref_q;

    logic          aref, cmd, start, cont, active;
    logic [CW-1:0] dl, gc_ext;

    assign aref   = (cmd_i == AREF);
    assign cmd    = (cmd_i != NOP);
    assign start  = aref & ~aref_q;
    assign cont   = aref & aref_q;
    assign active = (state_q != IDLE);
    assign dl     = (CW'(rf_sh_i) << RF_SHIFT) + CW'(1);
    assign gc_ext = CW'(gcnt_q);
    assign gcnt_o = gcnt_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        gcnt_d  = gcnt_q;
        late_d  = late_q;
        ev_o    = '0;
        if (!en_i) begin
            state_d = IDLE;
            rcnt_d  = '0;
            gcnt_d  = '0;
            late_d  = 1'b0;
        end else begin
            if (active) begin
                if (gcnt_q != '1) gcnt_d = gcnt_q + CNT_W'(1);
                if (!late_q && gc_ext == dl) begin
                    ev_o.err_late = 1'b1;
                    late_d        = 1'b1;
                end
            end
            if (state_q == RECOVER) begin
                if (rcnt_q != '1) rcnt_d = rcnt_q + TRCAR_W'(1);
                if (cmd && !cont && rcnt_q <= trcar_i) ev_o.err_trcar = 1'b1;
                if (rcnt_q >= trcar_i) state_d = ARMED;
            end
            // A fresh refresh restarts both windows from any state.
            if (start) begin
                ev_o.start = 1'b1;
                ev_o.gap   = active;
                state_d    = RECOVER;
                rcnt_d     = TRCAR_W'(1);
                gcnt_d     = CNT_W'(1);
                late_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            gcnt_q  <= '0;
            late_q  <= 1'b0;
            aref_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            gcnt_q  <= gcnt_d;
            late_q  <= late_d;
            aref_q  <= aref;
        end
    end

endmodule

// File: rtl/sdr_aref_checker.sv
// Multi chip-select SDRAM auto-refresh timing checker.
// Per-channel checkers merged by lowest-index priority into registered reports.
module sdr_aref_checker
    import sdr_cmd_pkg::*;
#(
    parameter int CS_NUM   = 1,
    parameter int CNT_W    = 16,
    parameter int RF_SHIFT = 0,
    parameter int TOT_W    = 24
) (
    input  logic                        sdram_clk,
    input  logic                        RESET,
    input  logic                        chk_en,
    input  logic                        sdr_cke,
    input  logic [CS_NUM-1:0]           sdr_cs_n,
    input  logic                        sdr_ras_n,
    input  logic                        sdr_cas_n,
    input  logic                        sdr_we_n,
    input  logic [TRCAR_W-1:0]          SDR_trcar_d,
    input  logic [RFSH_W-1:0]           SDR_rf_sh,
    output logic                        gap_valid,
    output logic [CNT_W-1:0]            gap_cycles,
    output logic [$clog2(CS_NUM):0]     gap_ch,
    output logic                        err_trcar,
    output logic                        err_late,
    output logic [$clog2(CS_NUM):0]     err_ch,
    output logic [CS_NUM-1:0]           err_mask,
    output logic [TOT_W-1:0]            aref_total
);

    localparam int CH_W = $clog2(CS_NUM) + 1;
    localparam int TS_W = TOT_W + 1;

    chan_ev_t         ev_a   [CS_NUM];
    logic [CNT_W-1:0] gcnt_a [CS_NUM];

    logic [CS_NUM-1:0] start_v, gap_v, trc_v, late_v, err_v;

    for (genvar c = 0; c < CS_NUM; c++) begin : g_ch
        sdr_cmd_e cmd;
        assign cmd = sdr_decode(sdr_cke, sdr_cs_n[c],
                                sdr_ras_n, sdr_cas_n, sdr_we_n);

        sdr_aref_chan #(
            .CNT_W    (CNT_W),
            .RF_SHIFT (RF_SHIFT)
        ) u_chan (
            .clk_i   (sdram_clk),
            .rst_i   (RESET),
            .en_i    (chk_en),
            .cmd_i   (cmd),
            .trcar_i (SDR_trcar_d),
            .rf_sh_i (SDR_rf_sh),
            .ev_o    (ev_a[c]),
            .gcnt_o  (gcnt_a[c])
        );

        assign start_v[c] = ev_a[c].start;
        assign gap_v[c]   = ev_a[c].gap;
        assign trc_v[c]   = ev_a[c].err_trcar;
        assign late_v[c]  = ev_a[c].err_late;
    end

    assign err_v = trc_v | late_v;

    logic              gap_valid_q, gap_valid_d;
    logic [CNT_W-1:0]  gap_cycles_q, gap_cycles_d;
    logic [CH_W-1:0]   gap_ch_q, gap_ch_d;
    logic              err_trcar_q, err_late_q;
    logic [CH_W-1:0]   err_ch_q, err_ch_d;
    logic [CS_NUM-1:0] err_mask_q;
    logic [TOT_W-1:0]  aref_total_q, aref_total_d;
    logic [CH_W-1:0]   pop;
    logic [TS_W-1:0]   sum;

    // Walk downward so the lowest active index wins.
    always_comb begin
        gap_valid_d  = |gap_v;
        gap_cycles_d = '0;
        gap_ch_d     = '0;
        err_ch_d     = '0;
        pop          = '0;
        for (int c = CS_NUM - 1; c >= 0; c--) begin
            if (gap_v[c]) begin
                gap_cycles_d = gcnt_a[c];
                gap_ch_d     = CH_W'(c);
            end
            if (err_v[c]) err_ch_d = CH_W'(c);
            pop = pop + CH_W'(start_v[c]);
        end
        sum          = {1'b0, aref_total_q} + TS_W'(pop);
        aref_total_d = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
    end

    always_ff @(posedge sdram_clk or posedge RESET) begin
        if (RESET) begin
            gap_valid_q  <= 1'b0;
            gap_cycles_q <= '0;
            gap_ch_q     <= '0;
            err_trcar_q  <= 1'b0;
            err_late_q   <= 1'b0;
            err_ch_q     <= '0;
            err_mask_q   <= '0;
            aref_total_q <= '0;
        end else begin
            gap_valid_q  <= gap_valid_d;
            gap_cycles_q <= gap_cycles_d;
            gap_ch_q     <= gap_ch_d;
            err_trcar_q  <= |trc_v;
            err_late_q   <= |late_v;
            err_ch_q     <= err_ch_d;
            err_mask_q   <= err_mask_q | err_v;
            aref_total_q <= aref_total_d;
        end
    end

    assign gap_valid  = gap_valid_q;
    assign gap_cycles = gap_cycles_q;
    assign gap_ch     = gap_ch_q;
    assign err_trcar  = err_trcar_q;
    assign err_late   = err_late_q;
    assign err_ch     = err_ch_q;
    assign err_mask   = err_mask_q;
    assign aref_total = aref_total_q;

endmodule

// File: tb/tb_sdr_aref_checker.sv
// Bench for sdr_aref_checker: directed refresh scenarios plus random bus
// traffic, compared each cycle against an elapsed-time reference model.
module tb_sdr_aref_checker;

    localparam int CS    = 4;
    localparam int CNT_W = 16;
    localparam int TOT_W = 24;
    localparam int CH_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             chk_en, cke;
    logic [CS-1:0]    cs_n;
    logic             ras_n, cas_n, we_n;
    logic [3:0]       trcar;
    logic [11:0]      rf_sh;
    logic             gap_valid, err_trcar, err_late;
    logic [CNT_W-1:0] gap_cycles;
    logic [CH_W-1:0]  gap_ch, err_ch;
    logic [CS-1:0]    err_mask;
    logic [TOT_W-1:0] aref_total;

    always #5 clk = ~clk;

    sdr_aref_checker #(
        .CS_NUM   (CS),
        .CNT_W    (CNT_W),
        .RF_SHIFT (0),
        .TOT_W    (TOT_W)
    ) dut (
        .sdram_clk   (clk),
        .RESET       (rst),
        .chk_en      (chk_en),
        .sdr_cke     (cke),
        .sdr_cs_n    (cs_n),
        .sdr_ras_n   (ras_n),
        .sdr_cas_n   (cas_n),
        .sdr_we_n    (we_n),
        .SDR_trcar_d (trcar),
        .SDR_rf_sh   (rf_sh),
        .gap_valid   (gap_valid),
        .gap_cycles  (gap_cycles),
        .gap_ch      (gap_ch),
        .err_trcar   (err_trcar),
        .err_late    (err_late),
        .err_ch      (err_ch),
        .err_mask    (err_mask),
        .aref_total  (aref_total)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: time of last refresh start per channel (-1 = idle)
    int           t;
    int           ts   [CS];
    bit           prev [CS];
    logic         e_gv, e_et, e_el;
    logic [15:0]  e_gc;
    logic [2:0]   e_gch, e_ech;
    logic [3:0]   e_mask;
    longint       e_tot;

    int o_gap, o_late, o_trc, last_gap, last_ech;

    task automatic model_clear();
        for (int c = 0; c < CS; c++) begin
            ts[c]   = -1;
            prev[c] = 1'b0;
        end
        e_gv = 0; e_gc = 0; e_gch = 0;
        e_et = 0; e_el = 0; e_ech = 0;
        e_mask = 0; e_tot = 0;
    endtask

    task automatic model_step(input logic k, input logic [3:0] csn,
                              input logic [2:0] rcw, input logic en);
        bit g_found, e_found;
        g_found = 0; e_found = 0;
        e_gv = 0; e_gc = 0; e_gch = 0;
        e_et = 0; e_el = 0; e_ech = 0;
        for (int c = 0; c < CS; c++) begin
            bit a, cm, st, trc, late;
            int el;
            a    = k && !csn[c] && (rcw == 3'b001);
            cm   = k && !csn[c] && (rcw != 3'b111);
            st   = a && !prev[c];
            trc  = 0;
            late = 0;
            if (!en) begin
                ts[c] = -1;
            end else begin
                if (ts[c] >= 0) begin
                    el = t - ts[c];
                    if (cm && !(a && prev[c]) && el <= int'(trcar)) trc = 1;
                    if (el == int'(rf_sh) + 1) late = 1;
                    if (st && !g_found) begin
                        g_found = 1;
                        e_gv    = 1;
                        e_gc    = (el > 65535) ? 16'hFFFF : 16'(el);
                        e_gch   = 3'(c);
                    end
                end
                if (st) begin
                    ts[c] = t;
                    if (e_tot < (64'd1 << TOT_W) - 1) e_tot++;
                end
            end
            prev[c] = a;
            if (trc) e_et = 1;
            if (late) e_el = 1;
            if ((trc || late) && !e_found) begin
                e_found = 1;
                e_ech   = 3'(c);
            end
            if (trc || late) e_mask[c] = 1'b1;
        end
        t++;
    endtask

    task automatic cyc(input logic k, input logic [3:0] csn,
                       input logic [2:0] rcw, input logic en, input logic r);
        @(negedge clk);
        expect_eq("gap_valid", gap_valid, e_gv);
        expect_eq("gap_cycles", gap_cycles, e_gc);
        expect_eq("gap_ch", gap_ch, e_gch);
        expect_eq("err_trcar", err_trcar, e_et);
        expect_eq("err_late", err_late, e_el);
        expect_eq("err_ch", err_ch, e_ech);
        expect_eq("err_mask", err_mask, e_mask);
        expect_eq("aref_total", aref_total, e_tot[31:0]);
        if (gap_valid) begin
            o_gap++;
            last_gap = int'(gap_cycles);
        end
        if (err_late) o_late++;
        if (err_trcar) begin
            o_trc++;
            last_ech = int'(err_ch);
        end
        cke = k;
        cs_n = csn;
        {ras_n, cas_n, we_n} = rcw;
        chk_en = en;
        rst = r;
        if (r) model_clear();
        else model_step(k, csn, rcw, en);
    endtask

    task automatic clr_obs();
        o_gap = 0; o_late = 0; o_trc = 0;
        last_gap = -1; last_ech = -1;
    endtask

    task automatic nop(input int n);
        repeat (n) cyc(1'b1, 4'hF, 3'b111, 1'b1, 1'b0);
    endtask

    task automatic aref(input logic [3:0] m);
        cyc(1'b1, ~m, 3'b001, 1'b1, 1'b0);
    endtask

    task automatic act(input logic [3:0] m);
        cyc(1'b1, ~m, 3'b011, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        repeat (3) cyc(1'b1, 4'hF, 3'b111, 1'b1, 1'b1);
        clr_obs();
    endtask

    initial begin
        logic [3:0] lm;
        logic [2:0] lr;
        int         rate;
        rst = 1'b1; chk_en = 1'b1; cke = 1'b1; cs_n = 4'hF;
        ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        trcar = 4'd4; rf_sh = 12'd1000;
        t = 0;
        model_clear();
        clr_obs();

        // Reset mid-window; first refresh after release is an idle start
        do_reset();
        aref(4'b0001);
        nop(10);
        do_reset();
        aref(4'b0001); nop(19);
        aref(4'b0001); nop(19);
        aref(4'b0001); nop(3);
        expect_eq("rst_total", aref_total, 3);
        expect_eq("rst_gaps", o_gap, 2);
        expect_eq("rst_gap_len", last_gap, 20);

        // Three refreshes 100 cycles apart
        do_reset();
        aref(4'b0001); nop(99);
        aref(4'b0001); nop(99);
        aref(4'b0001); nop(3);
        expect_eq("p100_total", aref_total, 3);
        expect_eq("p100_gaps", o_gap, 2);
        expect_eq("p100_len", last_gap, 100);
        expect_eq("p100_mask", err_mask, 0);

        // ACT inside and just outside the recovery window
        do_reset();
        aref(4'b0001); nop(2); act(4'b0001); nop(2);
        expect_eq("trc_in_cnt", o_trc, 1);
        expect_eq("trc_in_mask", err_mask, 1);
        do_reset();
        aref(4'b0001); nop(4); act(4'b0001); nop(2);
        expect_eq("trc_out_cnt", o_trc, 0);
        expect_eq("trc_out_mask", err_mask, 0);

        // Missed deadline
        do_reset();
        rf_sh = 12'd50;
        aref(4'b0001); nop(70); aref(4'b0001); nop(2);
        expect_eq("late_cnt", o_late, 1);
        expect_eq("late_gap", last_gap, 71);

        // Held refresh merges into one start
        do_reset();
        rf_sh = 12'd1000;
        aref(4'b0001); aref(4'b0001); aref(4'b0001); nop(6);
        expect_eq("hold_total", aref_total, 1);
        expect_eq("hold_trc", o_trc, 0);
        expect_eq("hold_gap", o_gap, 0);

        // Two channels refresh and violate together
        do_reset();
        aref(4'b1010); nop(1); act(4'b1010); nop(2);
        expect_eq("multi_total", aref_total, 2);
        expect_eq("multi_ch", last_ech, 1);
        expect_eq("multi_mask", err_mask, 4'b1010);

        // Disabled checker forgets prior refreshes
        nop(10);
        repeat (10) cyc(1'b1, 4'hF, 3'b111, 1'b0, 1'b0);
        clr_obs();
        aref(4'b0010); nop(2);
        expect_eq("dis_gap", o_gap, 0);
        expect_eq("dis_total", aref_total, 3);

        // Random traffic, config fixed per segment
        do_reset();
        lm = 4'hF; lr = 3'b111;
        for (int seg = 0; seg < 8; seg++) begin
            trcar = 4'($urandom_range(0, 15));
            rf_sh = 12'($urandom_range(15, 90));
            rate  = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 3 : 8);
            repeat (2) cyc(1'b1, 4'hF, 3'b111, 1'b0, 1'b0);
            for (int i = 0; i < 400; i++) begin
                int   r;
                logic k, en;
                r  = $urandom_range(0, 99);
                k  = ($urandom_range(0, 49) != 0);
                en = ($urandom_range(0, 199) != 0);
                if (r < rate) begin
                    lm = 4'($urandom_range(1, 15));
                    lr = 3'b001;
                end else if (r < rate + 5) begin
                    // hold previous command
                end else if (r < 60) begin
                    lm = 4'h0; lr = 3'b111;
                end else begin
                    lm = 4'($urandom_range(0, 15));
                    lr = 3'($urandom_range(0, 7));
                    if (lr == 3'b001) lr = 3'b011;
                end
                cyc(k, ~lm, lr, en, 1'b0);
            end
        end
        nop(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
